lfsr_seq_checker: RTL
=====================

# lfsr_seq_checker

- Receive-side checker for the parallel LFSR pattern generator.
- Takes the Length-bit LFSR state word produced each cycle by the generator, self-synchronises to it and declares lock after a run of correct predictions.
- Once locked, flywheels its own prediction and flags and counts mismatching words.
- Sits at the far end of a data path (link, FIFO, memory) driven by the generator, as a built-in pattern checker.

## Interface
- Length, 8, LFSR width in bits.
- Taps, 8'b1001_0001, feedback tap vector, indexed [1:Length]; must match the generator.
- LockCount, 4, consecutive correct predictions required to enter LOCKED (1..15).
- LossCount, 3, consecutive mismatches in LOCKED that drop lock (1..15).
- Clock  input  1  single clock, all state on rising edge.
- Reset  input  1  synchronous, active-high; clears all state.
- In_valid  input  1  Data_in carries a word this cycle.
- Data_in  input  [1:Length]  received LFSR state word.
- Clear_cnt  input  1  synchronous clear of Err_count (lower priority than Reset).
- Locked  output  1  checker is in LOCKED.
- Error  output  1  one-cycle pulse: last valid word mismatched while LOCKED.
- Err_count  output  16  saturating count of mismatches while LOCKED.

## Operation
- Next-state function nxt(c), identical to the generator:
  - nxt[1] = c[Length].
  - For k = 2..Length: nxt[k] = Taps[Length-k+1] ? c[k-1]^c[Length] : c[k-1].
- Registers:
  - pred[1:Length]: predicted next word.
  - run counter, 4 bits: counts matches or misses depending on state.
  - state.
- States: SEARCH, VERIFY, LOCKED. Words with In_valid=0 are ignored in every state; nothing advances.
- SEARCH:
  - Valid nonzero word: pred <= nxt(Data_in), run <= 0, go to VERIFY.
  - Valid all-zero word (lockup state): ignored, stay in SEARCH.
- VERIFY:
  - Data_in == pred: pred <= nxt(Data_in), run <= run+1. If run+1 == LockCount, go to LOCKED with run <= 0.
  - Mismatch: reseed. If Data_in is nonzero, pred <= nxt(Data_in), run <= 0, stay in VERIFY. If Data_in is zero, go to SEARCH.
- LOCKED (flywheel):
  - pred <= nxt(pred) on every valid word, regardless of match.
  - Match: run <= 0.
  - Mismatch: Error pulses, Err_count increments, run <= run+1. If run+1 == LossCount, go to SEARCH.
- Err_count saturates at 16'hFFFF.
- Clear_cnt and a mismatch in the same cycle: the result is 0 (clear wins).
- Err_count is held, not cleared, when lock is lost.
- Reset mid-operation: next edge returns to SEARCH, pred=0, run=0, all outputs 0.

## Timing
- Reset values: Locked=0, Error=0, Err_count=0, state SEARCH.
- All outputs are registered.
- Error and Err_count reflect word N on the cycle after word N is sampled (latency 1).
- Locked rises on the cycle after the LockCount-th correct prediction is sampled.
- From the first valid nonzero word, minimum lock time is LockCount+1 valid words.
- Locked falls on the cycle after the LossCount-th consecutive mismatch; that final mismatch still pulses Error.
- No backpressure: a word is accepted in every cycle that In_valid=1.

## Configuration
- Macro: LFSR_CHK_ERR_CNT_EN.
- Defined: the 16-bit saturating Err_count and the Clear_cnt logic are built.
- Undefined: Err_count is driven constant 0 and Clear_cnt is ignored. Error and Locked are unchanged.

## Structure
- Shared package lfsr_pkg holds:
  - the state enum (SEARCH, VERIFY, LOCKED);
  - the default Length/Taps constants, shared with the generator;
  - the counter width constant (16).
- Sub-module lfsr_next_state: purely combinational nxt() over Length/Taps. Instantiated here for both the reseed path and the flywheel path, and reusable by the generator.

## Test plan
- Reference vectors (Length=8, Taps=8'b1001_0001):
  - nxt(8'b1111_0011) = 8'b1111_0000.
  - nxt(8'b1111_0000) = 8'b0111_1000.
  - The checker must accept these as matches.
- Clean lock: generator seeded 8'b1111_0011, In_valid=1 every cycle. Locked=1 on the cycle after the 5th word. Error stays 0 and Err_count stays 0 over 300 words.
- Single-bit error: after lock, invert Data_in[3] on one word. Error pulses once the next cycle, Err_count=1, Locked stays 1, the following words match.
- Lock loss and reacquire: after lock, force 3 consecutive wrong words. Err_count=3 and Locked=0 after the 3rd. With clean data resumed, Locked=1 again 5 valid words later.
- Zero and gaps: all-zero words in SEARCH never leave SEARCH. With In_valid toggling 1/0 on a clean stream, lock still arrives after 5 valid words.
- Reset and saturation:
  - Reset asserted while LOCKED: all outputs 0 on the next cycle.
  - Err_count preloaded via 65 535 forced mismatches (LossCount=15, periodic clean words) stays at 16'hFFFF.
  - Clear_cnt then returns Err_count to 0.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: default width/taps (common with the generator),
// checker state encoding, run/error counter widths and the status payload.
package lfsr_pkg;

    localparam int unsigned LFSR_LEN  = 8;
    localparam logic [1:LFSR_LEN] LFSR_TAPS = 8'b1001_0001;
    localparam int unsigned ERR_CNT_W = 16;
    localparam int unsigned RUN_W     = 4;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_e;

    // Checker status returned to the consumer of the pattern check
    typedef struct packed {
        logic                 locked;
        logic                 error;
        logic [ERR_CNT_W-1:0] err_count;
    } chk_status_t;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == '1) ? v : ERR_CNT_W'(v + ERR_CNT_W'(1));
    endfunction

endpackage

// File: rtl/lfsr_seq_checker_if.sv
// Checker bus: received LFSR words and count clear in, status payload out.
interface lfsr_seq_checker_if import lfsr_pkg::*; #(
    parameter int unsigned LENGTH = LFSR_LEN
);
    logic              in_valid;
    logic [1:LENGTH]   data_in;
    logic              clear_cnt;
    chk_status_t       status;

    modport master (
        output in_valid, data_in, clear_cnt,
        input  status
    );

    modport slave (
        input  in_valid, data_in, clear_cnt,
        output status
    );
endinterface

// File: rtl/lfsr_next_state.sv
// Combinational LFSR step, bit-identical to the generator's next-state function.
module lfsr_next_state import lfsr_pkg::*; #(
    parameter int unsigned     LENGTH = LFSR_LEN,
    parameter logic [1:LENGTH] TAPS   = LFSR_TAPS
) (
    input  logic [1:LENGTH] i_cur,
    output logic [1:LENGTH] o_nxt_c
);

    // Bit 1 takes the feedback bit; tapped stages fold it into the shifted bit
    always_comb begin
        o_nxt_c    = '0;
        o_nxt_c[1] = i_cur[LENGTH];
        for (int k = 2; k <= int'(LENGTH); k++) begin
            o_nxt_c[k] = TAPS[int'(LENGTH) - k + 1] ? (i_cur[k-1] ^ i_cur[LENGTH])
                                                    : i_cur[k-1];
        end
    end

endmodule

// File: rtl/lfsr_seq_checker.sv
// Receive-side LFSR pattern checker: self-synchronises, locks, then flywheels.
// Optional LFSR_CHK_ERR_CNT_EN builds the saturating error counter and its clear.
module lfsr_seq_checker import lfsr_pkg::*; #(
    parameter int unsigned     LENGTH     = LFSR_LEN,
    parameter logic [1:LENGTH] TAPS       = LFSR_TAPS,
    parameter int unsigned     LOCK_COUNT = 4,
    parameter int unsigned     LOSS_COUNT = 3
) (
    input  logic               i_clk,
    input  logic               i_rst,
    lfsr_seq_checker_if.slave  io_bus
);

    chk_state_e           r_state, w_state_nxt;
    logic [1:LENGTH]      r_pred, w_pred_nxt;
    logic [1:LENGTH]      w_nxt_data, w_nxt_pred;
    logic [RUN_W-1:0]     r_run, w_run_nxt, w_run_inc;
    logic                 r_locked, r_error, w_error_nxt;
    logic                 w_match, w_data_zero;
    logic [ERR_CNT_W-1:0] w_err_count;

    // Reseed path follows the received word; flywheel path follows our own prediction
    lfsr_next_state #(.LENGTH(LENGTH), .TAPS(TAPS)) u_nxt_data (
        .i_cur   (io_bus.data_in),
        .o_nxt_c (w_nxt_data)
    );

    lfsr_next_state #(.LENGTH(LENGTH), .TAPS(TAPS)) u_nxt_pred (
        .i_cur   (r_pred),
        .o_nxt_c (w_nxt_pred)
    );

    assign w_match     = (io_bus.data_in == r_pred);
    assign w_data_zero = (io_bus.data_in == '0);
    assign w_run_inc   = RUN_W'(r_run + RUN_W'(1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= SEARCH;
            r_pred   <= '0;
            r_run    <= '0;
            r_locked <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pred   <= w_pred_nxt;
            r_run    <= w_run_nxt;
            r_locked <= (w_state_nxt == LOCKED);
            r_error  <= w_error_nxt;
        end
    end

    // Invalid cycles fall through on the defaults, so nothing advances
    always_comb begin
        w_state_nxt = r_state;
        w_pred_nxt  = r_pred;
        w_run_nxt   = r_run;
        w_error_nxt = 1'b0;

        if (io_bus.in_valid) begin
            unique case (r_state)
                SEARCH: begin
                    if (!w_data_zero) begin
                        w_pred_nxt  = w_nxt_data;
                        w_run_nxt   = '0;
                        w_state_nxt = VERIFY;
                    end
                end

                VERIFY: begin
                    if (w_match) begin
                        w_pred_nxt = w_nxt_data;
                        if (w_run_inc == RUN_W'(LOCK_COUNT)) begin
                            w_run_nxt   = '0;
                            w_state_nxt = LOCKED;
                        end else begin
                            w_run_nxt = w_run_inc;
                        end
                    end else if (!w_data_zero) begin
                        w_pred_nxt = w_nxt_data;
                        w_run_nxt  = '0;
                    end else begin
                        w_run_nxt   = '0;
                        w_state_nxt = SEARCH;
                    end
                end

                LOCKED: begin
                    w_pred_nxt = w_nxt_pred;
                    if (w_match) begin
                        w_run_nxt = '0;
                    end else begin
                        w_error_nxt = 1'b1;
                        if (w_run_inc == RUN_W'(LOSS_COUNT)) begin
                            w_run_nxt   = '0;
                            w_state_nxt = SEARCH;
                        end else begin
                            w_run_nxt = w_run_inc;
                        end
                    end
                end

                default: begin
                    w_run_nxt   = '0;
                    w_state_nxt = SEARCH;
                end
            endcase
        end
    end

`ifdef LFSR_CHK_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] r_err_cnt, w_err_cnt_nxt;

    // Clear beats a simultaneous mismatch; count survives loss of lock
    always_comb begin
        w_err_cnt_nxt = r_err_cnt;
        if (io_bus.clear_cnt) begin
            w_err_cnt_nxt = '0;
        end else if (w_error_nxt) begin
            w_err_cnt_nxt = sat_inc(r_err_cnt);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_err_cnt <= '0;
        end else begin
            r_err_cnt <= w_err_cnt_nxt;
        end
    end

    assign w_err_count = r_err_cnt;
`else
    logic w_unused_clear;

    assign w_unused_clear = io_bus.clear_cnt;
    assign w_err_count    = '0;
`endif

    assign io_bus.status = '{locked: r_locked, error: r_error, err_count: w_err_count};

endmodule
